// File: rtl/ysyx_23060221_clint_pkg.sv
// Shared constants and FSM state types for the CLINT mtime slave.
package ysyx_23060221_clint_pkg;

    localparam logic [31:0] MTIME_LO_OFF = 32'd0;
    localparam logic [31:0] MTIME_HI_OFF = 32'd4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic {
        R_IDLE,
        R_BURST
    } r_state_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_e;

endpackage

// File: rtl/ysyx_23060221_mtime.sv
// 64-bit mtime counter with a TICK_DIV prescaler and a byte-enabled 32-bit write port.
// A write beat wins over a tick in the same cycle and restarts the prescaler.
module ysyx_23060221_mtime #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        wr_hi,
    input  logic [3:0]  wr_strb,
    input  logic [31:0] wr_data,
    output logic [63:0] mtime
);

    logic [31:0] prescaler_q;
    logic [63:0] mtime_q;
    logic [31:0] wr_word;
    logic [63:0] mtime_wr;
    logic        tick;

    assign tick  = (prescaler_q == 32'(TICK_DIV - 1));
    assign mtime = mtime_q;

    // Merge the selected bytes of the write data into the addressed word.
    always_comb begin
        wr_word  = wr_hi ? mtime_q[63:32] : mtime_q[31:0];
        for (int b = 0; b < 4; b++) begin
            if (wr_strb[b]) wr_word[8*b +: 8] = wr_data[8*b +: 8];
        end
        mtime_wr = mtime_q;
        if (wr_hi) mtime_wr[63:32] = wr_word;
        else       mtime_wr[31:0]  = wr_word;
    end

    // Prescaler and counter update; bus write has priority over a tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler_q <= '0;
            mtime_q     <= '0;
        end else if (wr_en) begin
            prescaler_q <= '0;
            mtime_q     <= mtime_wr;
        end else if (tick) begin
            prescaler_q <= '0;
            mtime_q     <= mtime_q + 64'd1;
        end else begin
            prescaler_q <= prescaler_q + 32'd1;
        end
    end

endmodule

// File: rtl/ysyx_23060221_clint.sv
// CLINT AXI4 slave exposing mtime as two 32-bit words at BASE_ADDR / BASE_ADDR+4.
// Bus writes to mtime only exist when YSYX_23060221_CLINT_WRITE_EN is defined;
// otherwise write beats are swallowed and answered with SLVERR.
module ysyx_23060221_clint
    import ysyx_23060221_clint_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
    parameter int unsigned TICK_DIV  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        arvalid,
    output logic        arready,
    input  logic [31:0] araddr,
    input  logic [3:0]  arid,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    output logic        rvalid,
    input  logic        rready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic [3:0]  rid,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] awaddr,
    input  logic [3:0]  awid,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic        wvalid,
    output logic        wready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    output logic        bvalid,
    input  logic        bready,
    output logic [1:0]  bresp,
    output logic [3:0]  bid
);

    r_state_e    r_state_q, r_state_d;
    logic [3:0]  r_id_q;
    logic [31:0] r_addr_q;
    logic [7:0]  r_cnt_q;
    logic [63:0] snap_q;
    w_state_e    w_state_q, w_state_d;
    logic [3:0]  w_id_q;
    logic [31:0] w_addr_q;
    logic [63:0] mtime;
    logic        ar_hs, r_hs, aw_hs, w_hs;
    logic        w_hit_lo, w_hit_hi, mt_we;
    logic [1:0]  b_code;

    // Burst type/size are fixed to 4-byte INCR; these inputs carry no information.
    logic unused_axi;
    assign unused_axi = ^{arsize, arburst, awlen, awsize, awburst};

    assign ar_hs    = arvalid && arready;
    assign r_hs     = rvalid && rready;
    assign aw_hs    = awvalid && awready;
    assign w_hs     = wvalid && wready;
    assign w_hit_lo = (w_addr_q == BASE_ADDR + MTIME_LO_OFF);
    assign w_hit_hi = (w_addr_q == BASE_ADDR + MTIME_HI_OFF);

`ifdef YSYX_23060221_CLINT_WRITE_EN
    logic w_err_q;
    assign mt_we  = w_hs && (w_hit_lo || w_hit_hi);
    assign b_code = w_err_q ? RESP_DECERR : RESP_OKAY;

    // Sticky miss flag across the beats of one write burst.
    always_ff @(posedge clk) begin
        if (rst)        w_err_q <= 1'b0;
        else if (aw_hs) w_err_q <= 1'b0;
        else if (w_hs)  w_err_q <= w_err_q | ~(w_hit_lo | w_hit_hi);
    end
`else
    logic unused_whit;
    assign unused_whit = w_hit_lo;
    assign mt_we       = 1'b0;
    assign b_code      = RESP_SLVERR;
`endif

    ysyx_23060221_mtime #(
        .TICK_DIV (TICK_DIV)
    ) u_mtime (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (mt_we),
        .wr_hi   (w_hit_hi),
        .wr_strb (wstrb),
        .wr_data (wdata),
        .mtime   (mtime)
    );

    // Read channel outputs; payload is zero whenever no beat is presented.
    always_comb begin
        arready = (r_state_q == R_IDLE);
        rvalid  = (r_state_q == R_BURST);
        rlast   = rvalid && (r_cnt_q == 8'd0);
        rid     = rvalid ? r_id_q : 4'd0;
        rdata   = 32'd0;
        rresp   = RESP_OKAY;
        if (rvalid) begin
            if (r_addr_q == BASE_ADDR + MTIME_LO_OFF)      rdata = snap_q[31:0];
            else if (r_addr_q == BASE_ADDR + MTIME_HI_OFF) rdata = snap_q[63:32];
            else                                           rresp = RESP_DECERR;
        end
    end

    // Read FSM next state.
    always_comb begin
        r_state_d = r_state_q;
        unique case (r_state_q)
            R_IDLE:  if (ar_hs) r_state_d = R_BURST;
            R_BURST: if (r_hs && rlast) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    // Read state and burst context; the whole burst is served from one snapshot.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            r_id_q    <= '0;
            r_addr_q  <= '0;
            r_cnt_q   <= '0;
            snap_q    <= '0;
        end else begin
            r_state_q <= r_state_d;
            if (ar_hs) begin
                r_id_q   <= arid;
                r_addr_q <= araddr;
                r_cnt_q  <= arlen;
                snap_q   <= mtime;
            end else if (r_hs && !rlast) begin
                r_cnt_q  <= r_cnt_q - 8'd1;
                r_addr_q <= r_addr_q + 32'd4;
            end
        end
    end

    // Write channel outputs.
    always_comb begin
        awready = (w_state_q == W_IDLE);
        wready  = (w_state_q == W_DATA);
        bvalid  = (w_state_q == W_RESP);
        bid     = bvalid ? w_id_q : 4'd0;
        bresp   = bvalid ? b_code : RESP_OKAY;
    end

    // Write FSM next state.
    always_comb begin
        w_state_d = w_state_q;
        unique case (w_state_q)
            W_IDLE:  if (aw_hs) w_state_d = W_DATA;
            W_DATA:  if (w_hs && wlast) w_state_d = W_RESP;
            W_RESP:  if (bready) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    // Write state, ID and running beat address.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            w_id_q    <= '0;
            w_addr_q  <= '0;
        end else begin
            w_state_q <= w_state_d;
            if (aw_hs) begin
                w_id_q   <= awid;
                w_addr_q <= awaddr;
            end else if (w_hs) begin
                w_addr_q <= w_addr_q + 32'd4;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_23060221_clint.sv
// Directed bench: one DUT with TICK_DIV=1 and one with TICK_DIV=4 share all inputs.
// Define YSYX_23060221_CLINT_WRITE_EN for both RTL and bench to exercise timer writes.
module tb_ysyx_23060221_clint;

    localparam logic [31:0] BASE = 32'h0200_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        arvalid, rready, awvalid, wvalid, wlast, bready;
    logic [31:0] araddr, awaddr, wdata;
    logic [3:0]  arid, awid, wstrb;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst, awburst;

    logic        arready, rvalid, rlast, awready, wready, bvalid;
    logic [31:0] rdata;
    logic [1:0]  rresp, bresp;
    logic [3:0]  rid, bid;
    logic        arready4, rvalid4, rlast4, awready4, wready4, bvalid4;
    logic [31:0] rdata4;
    logic [1:0]  rresp4, bresp4;
    logic [3:0]  rid4, bid4;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int snap;
    int cw;

    ysyx_23060221_clint #(.BASE_ADDR(BASE), .TICK_DIV(1)) u_dut (
        .clk(clk), .rst(rst),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid), .arlen(arlen),
        .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rid(rid),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid), .awlen(awlen),
        .awsize(awsize), .awburst(awburst),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid)
    );

    ysyx_23060221_clint #(.BASE_ADDR(BASE), .TICK_DIV(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .arvalid(arvalid), .arready(arready4), .araddr(araddr), .arid(arid), .arlen(arlen),
        .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid4), .rready(rready), .rdata(rdata4), .rresp(rresp4), .rlast(rlast4),
        .rid(rid4),
        .awvalid(awvalid), .awready(awready4), .awaddr(awaddr), .awid(awid), .awlen(awlen),
        .awsize(awsize), .awburst(awburst),
        .wvalid(wvalid), .wready(wready4), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid4), .bready(bready), .bresp(bresp4), .bid(bid4)
    );

    always #5 clk = ~clk;

    // Reference timer: cycles since reset, equal to mtime when TICK_DIV=1.
    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present AR at the current negedge; snapshot equals the reference timer this cycle.
    task automatic ar_start(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                            output int s);
        check_eq("arready_idle", 64'(arready), 64'd1);
        arvalid = 1'b1;
        araddr  = addr;
        arid    = id;
        arlen   = len;
        s       = cyc;
        @(negedge clk);
        arvalid = 1'b0;
    endtask

    task automatic take_beat(input string tag, input logic [31:0] d, input logic [1:0] resp,
                             input logic last, input logic [3:0] id);
        check_eq(tag, 64'({rvalid, rlast, rresp, rid, rdata}), 64'({1'b1, last, resp, id, d}));
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
    endtask

    task automatic aw_start(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len);
        awvalid = 1'b1;
        awaddr  = addr;
        awid    = id;
        awlen   = len;
        @(negedge clk);
        awvalid = 1'b0;
        check_eq("aw_to_wready", 64'({awready, wready}), 64'(2'b01));
    endtask

    task automatic write_beat(input logic [31:0] d, input logic [3:0] strb, input logic last);
        wvalid = 1'b1;
        wdata  = d;
        wstrb  = strb;
        wlast  = last;
        @(negedge clk);
        wvalid = 1'b0;
        wlast  = 1'b0;
    endtask

    initial begin
        arvalid = 0; rready = 0; awvalid = 0; wvalid = 0; wlast = 0; bready = 0;
        araddr = 0; awaddr = 0; wdata = 0; arid = 0; awid = 0; wstrb = 0;
        arlen = 0; awlen = 0; arsize = 3'd2; awsize = 3'd2; arburst = 2'b01; awburst = 2'b01;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("reset_ready", 64'({arready, awready, rvalid, wready, bvalid}), 64'(5'b11000));
        check_eq("reset_r", 64'({rdata, rresp, rlast, rid}), 64'd0);
        check_eq("reset_b", 64'({bresp, bid}), 64'd0);
        rst = 1'b0;

        // AR handshake with mtime == 10
        while (cyc != 10) @(negedge clk);
        ar_start(BASE, 4'h3, 8'd0, snap);
        check_eq("t1_div4", 64'(rdata4), 64'd2);
        take_beat("t1_beat", 32'd10, 2'b00, 1'b1, 4'h3);
        check_eq("t1_idle", 64'({rvalid, arready}), 64'(2'b01));

        // Two-beat burst with rready stalled: payload holds, both beats from one snapshot
        ar_start(BASE, 4'h1, 8'd1, snap);
        repeat (3) begin
            check_eq("stall_hold", 64'({rvalid, rlast, rresp, rdata}),
                     64'({1'b1, 1'b0, 2'b00, 32'(snap)}));
            @(negedge clk);
        end
        take_beat("stall_b0", 32'(snap), 2'b00, 1'b0, 4'h1);
        take_beat("stall_b1", 32'd0, 2'b00, 1'b1, 4'h1);

        // Address decode
        ar_start(BASE + 32'd8, 4'h2, 8'd0, snap);
        take_beat("decerr", 32'd0, 2'b11, 1'b1, 4'h2);
        ar_start(BASE + 32'd4, 4'h2, 8'd1, snap);
        take_beat("hi_b0", 32'd0, 2'b00, 1'b0, 4'h2);
        take_beat("hi_b1", 32'd0, 2'b11, 1'b1, 4'h2);

        // Back-to-back reads: TICK_DIV=4 counter steps every 4 clocks
        for (int k = 0; k < 4; k++) begin
            ar_start(BASE, k[3:0], 8'd0, snap);
            check_eq("div4_rdata", 64'(rdata4), 64'(snap / 4));
            take_beat("div1_rdata", 32'(snap), 2'b00, 1'b1, k[3:0]);
        end

`ifdef YSYX_23060221_CLINT_WRITE_EN
        // Partial write of word 0 on a tick cycle
        aw_start(BASE, 4'h5, 8'd0);
        write_beat(32'h1234_5678, 4'b0011, 1'b1);
        cw = cyc;
        check_eq("wr_b", 64'({bvalid, bresp, bid}), 64'({1'b1, 2'b00, 4'h5}));
        bready = 1'b1;
        ar_start(BASE, 4'h0, 8'd0, snap);
        bready = 1'b0;
        check_eq("wr_b_done", 64'({bvalid, awready}), 64'(2'b01));
        check_eq("wr_lo4", 64'(rdata4), 64'h5678);
        take_beat("wr_lo", 32'h5678, 2'b00, 1'b1, 4'h0);
        repeat (5) @(negedge clk);
        ar_start(BASE, 4'h0, 8'd0, snap);
        check_eq("wr_inc4", 64'(rdata4), 64'(32'h5678 + (snap - cw) / 4));
        take_beat("wr_inc", 32'h5678 + 32'(snap - cw), 2'b00, 1'b1, 4'h0);

        // Preload 1_FFFF_FFFF, then a stalled two-beat read must stay coherent
        aw_start(BASE, 4'h6, 8'd1);
        write_beat(32'hFFFF_FFFF, 4'hF, 1'b0);
        write_beat(32'h0000_0001, 4'hF, 1'b1);
        check_eq("pre_b", 64'({bvalid, bresp, bid}), 64'({1'b1, 2'b00, 4'h6}));
        bready = 1'b1;
        ar_start(BASE, 4'h7, 8'd1, snap);
        bready = 1'b0;
        check_eq("pre_lo4", 64'(rdata4), 64'hFFFF_FFFF);
        repeat (3) @(negedge clk);
        take_beat("pre_b0", 32'hFFFF_FFFF, 2'b00, 1'b0, 4'h7);
        take_beat("pre_b1", 32'h0000_0001, 2'b00, 1'b1, 4'h7);
`else
        // Write is swallowed with SLVERR; timer keeps counting
        aw_start(BASE, 4'h5, 8'd0);
        write_beat(32'd5, 4'hF, 1'b1);
        check_eq("wr_b", 64'({bvalid, wready, bresp, bid}), 64'({1'b1, 1'b0, 2'b10, 4'h5}));
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        check_eq("wr_b_done", 64'({bvalid, awready}), 64'(2'b01));
        ar_start(BASE, 4'h0, 8'd0, snap);
        check_eq("wr_ign4", 64'(rdata4), 64'(snap / 4));
        take_beat("wr_ign", 32'(snap), 2'b00, 1'b1, 4'h0);
`endif

        // Reset in the middle of a burst
        ar_start(BASE, 4'h9, 8'd3, snap);
        check_eq("mid_rvalid", 64'(rvalid), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst_mid", 64'({rvalid, arready, rlast, rid, rdata}),
                 64'({1'b0, 1'b1, 1'b0, 4'h0, 32'h0}));
        check_eq("rst_mid4", 64'({rvalid4, arready4}), 64'(2'b01));
        rst = 1'b0;
        ar_start(BASE, 4'h1, 8'd0, snap);
        check_eq("rst_mtime4", 64'(rdata4), 64'd0);
        take_beat("rst_mtime", 32'd0, 2'b00, 1'b1, 4'h1);
        while (cyc != 9) @(negedge clk);
        ar_start(BASE, 4'h1, 8'd0, snap);
        check_eq("post_rst4", 64'(rdata4), 64'd2);
        take_beat("post_rst", 32'd9, 2'b00, 1'b1, 4'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
